// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keypad decoder: frame FSM states,
// special scan codes, keypad scan-code table and the scan-code to nibble map.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  localparam int TIMEOUT_CYCLES_DEF = 50000;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  localparam logic [7:0] SC_KEY_0     = 8'h45;
  localparam logic [7:0] SC_KEY_1     = 8'h16;
  localparam logic [7:0] SC_KEY_2     = 8'h1E;
  localparam logic [7:0] SC_KEY_3     = 8'h26;
  localparam logic [7:0] SC_KEY_4     = 8'h25;
  localparam logic [7:0] SC_KEY_5     = 8'h2E;
  localparam logic [7:0] SC_KEY_6     = 8'h36;
  localparam logic [7:0] SC_KEY_7     = 8'h3D;
  localparam logic [7:0] SC_KEY_8     = 8'h3E;
  localparam logic [7:0] SC_KEY_9     = 8'h46;
  localparam logic [7:0] SC_KEY_PLUS  = 8'h79;
  localparam logic [7:0] SC_KEY_MINUS = 8'h7B;

  localparam logic [3:0] KEY_OTHER = 4'hC;

  function automatic logic [3:0] map_scan(input logic [7:0] sc);
    logic [3:0] nib;
    case (sc)
      SC_KEY_0:     nib = 4'h0;
      SC_KEY_1:     nib = 4'h1;
      SC_KEY_2:     nib = 4'h2;
      SC_KEY_3:     nib = 4'h3;
      SC_KEY_4:     nib = 4'h4;
      SC_KEY_5:     nib = 4'h5;
      SC_KEY_6:     nib = 4'h6;
      SC_KEY_7:     nib = 4'h7;
      SC_KEY_8:     nib = 4'h8;
      SC_KEY_9:     nib = 4'h9;
      SC_KEY_PLUS:  nib = 4'hA;
      SC_KEY_MINUS: nib = 4'hB;
      default:      nib = KEY_OTHER;
    endcase
    return nib;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronises the raw bus, detects ps2_clk falling edges,
// assembles 11-bit frames and flags parity, stop-bit and inter-edge timeout errors.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       err_stb
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic             r_clk_s1, r_clk_s2, r_clk_prev;
  logic             r_dat_s1, r_dat_s2;
  logic             w_fall;
  ps2_state_t       r_state;
  logic [2:0]       r_bitcnt;
  logic             r_parity;
  logic [7:0]       r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic             r_byte_stb, r_err_stb;

  assign w_fall   = r_clk_prev & ~r_clk_s2;
  assign rx_byte  = r_shift;
  assign byte_stb = r_byte_stb;
  assign err_stb  = r_err_stb;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s1   <= 1'b1;
      r_clk_s2   <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_s1   <= 1'b1;
      r_dat_s2   <= 1'b1;
      r_state    <= ST_IDLE;
      r_bitcnt   <= 3'd0;
      r_parity   <= 1'b0;
      r_cnt      <= '0;
      r_byte_stb <= 1'b0;
      r_err_stb  <= 1'b0;
    end else begin
      r_clk_s1   <= ps2_clk;
      r_clk_s2   <= r_clk_s1;
      r_clk_prev <= r_clk_s2;
      r_dat_s1   <= ps2_data;
      r_dat_s2   <= r_dat_s1;
      r_byte_stb <= 1'b0;
      r_err_stb  <= 1'b0;

      if (r_state == ST_IDLE || w_fall)
        r_cnt <= '0;
      else if (r_cnt != CNT_LAST)
        r_cnt <= r_cnt + CNT_W'(1);

      if (w_fall) begin
        case (r_state)
          ST_IDLE: begin
            if (!r_dat_s2) begin
              r_state  <= ST_DATA;
              r_bitcnt <= 3'd0;
            end
          end
          ST_DATA: begin
            r_bitcnt <= r_bitcnt + 3'd1;
            if (r_bitcnt == 3'd7)
              r_state <= ST_PARITY;
          end
          ST_PARITY: begin
            r_parity <= r_dat_s2;
            r_state  <= ST_STOP;
          end
          default: begin
            // Odd parity: data bits plus parity bit must have odd weight.
            if (r_dat_s2 && (^{r_shift, r_parity}))
              r_byte_stb <= 1'b1;
            else
              r_err_stb  <= 1'b1;
            r_state <= ST_IDLE;
          end
        endcase
      end else if (r_state != ST_IDLE && r_cnt == CNT_LAST) begin
        r_state   <= ST_IDLE;
        r_err_stb <= 1'b1;
      end
    end
  end

  // Data shift register carries no reset; it is only consumed alongside byte_stb.
  always_ff @(posedge clk) begin
    if (r_state == ST_DATA && w_fall)
      r_shift <= {r_dat_s2, r_shift[7:1]};
  end

endmodule

// File: rtl/ps2_keypad_decoder.sv
// PS/2 keypad decoder top: filters break/extended prefixes from received bytes and
// presents each key press as a 4-bit code with a one-cycle valid pulse.
module ps2_keypad_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       frame_err
);

  logic [7:0] w_byte;
  logic       w_byte_stb;
  logic       w_err_stb;
  logic       r_break;
  logic [3:0] r_key_code;
  logic       r_key_valid;
  logic       r_frame_err;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (w_byte),
    .byte_stb (w_byte_stb),
    .err_stb  (w_err_stb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_break     <= 1'b0;
      r_key_code  <= 4'h0;
      r_key_valid <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      r_frame_err <= w_err_stb;
      if (w_byte_stb) begin
        if (w_byte == SC_BREAK) begin
          r_break <= 1'b1;
        end else if (w_byte == SC_EXT) begin
          r_break <= r_break;
        end else if (r_break) begin
          // Byte following F0 is the released key: swallow it.
          r_break <= 1'b0;
        end else begin
          r_key_code  <= map_scan(w_byte);
          r_key_valid <= 1'b1;
        end
      end
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_keypad_decoder.sv
// Scoreboard bench for ps2_keypad_decoder: frames are bit-banged onto the PS/2 pins,
// expected pulses are queued at stimulus time and matched by an independent monitor.
module tb_ps2_keypad_decoder;

  localparam int TO = 100;

  typedef struct {
    bit         is_err;
    logic [3:0] code;
    int         cyc_lo;
    int         cyc_hi;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] key_code;
  logic       key_valid;
  logic       frame_err;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   last_fall = 0;

  ps2_keypad_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_code  (key_code),
    .key_valid (key_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of the expectation queue.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && (key_valid || frame_err)) begin
        n_checks++;
        if (key_valid && frame_err) begin
          n_errors++;
          $display("FAIL both_pulses: key_valid and frame_err together at cycle %0d", cyc);
        end else if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL unexpected_pulse: valid=%0b err=%0b code=%0h at cycle %0d, none expected",
                   key_valid, frame_err, key_code, cyc);
        end else begin
          e = exp_q.pop_front();
          if (frame_err != e.is_err) begin
            n_errors++;
            $display("FAIL pulse_kind: got err=%0b, expected err=%0b", frame_err, e.is_err);
          end else if (!e.is_err && key_code != e.code) begin
            n_errors++;
            $display("FAIL key_code: got %0h, expected %0h", key_code, e.code);
          end else if (cyc < e.cyc_lo || cyc > e.cyc_hi) begin
            n_errors++;
            $display("FAIL pulse_cycle: got cycle %0d, expected %0d..%0d", cyc, e.cyc_lo, e.cyc_hi);
          end
        end
      end
    end
  end

  // kind: 0 = no output expected, 1 = key_valid with code, 2 = frame_err
  task automatic send_bit(input logic b, input bit last, input int kind, input logic [3:0] code);
    exp_t e;
    @(negedge clk);
    ps2_data = b;
    repeat (9) @(negedge clk);
    ps2_clk = 1'b0;
    last_fall = cyc;
    if (last && kind != 0) begin
      e.is_err = (kind == 2);
      e.code   = code;
      e.cyc_lo = cyc + 4;
      e.cyc_hi = cyc + 4;
      exp_q.push_back(e);
    end
    repeat (10) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip_par, input int kind,
                            input logic [3:0] code);
    logic par;
    par = ~(^b) ^ flip_par;
    send_bit(1'b0, 1'b0, 0, 4'h0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0, 0, 4'h0);
    send_bit(par, 1'b0, 0, 4'h0);
    send_bit(1'b1, 1'b1, kind, code);
    ps2_data = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] pb;
    exp_t e;
    repeat (4) @(negedge clk);
    check("reset_key_code", key_code, 4'h0);
    check("reset_key_valid", key_valid, 0);
    check("reset_frame_err", frame_err, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // Single press with latency check
    send_frame(8'h16, 1'b0, 1, 4'h1);
    drain("press_16");
    repeat (20) @(negedge clk);
    check("held_after_16", key_code, 4'h1);

    // Press, break prefix, release
    send_frame(8'h45, 1'b0, 1, 4'h0);
    send_frame(8'hF0, 1'b0, 0, 4'h0);
    send_frame(8'h45, 1'b0, 0, 4'h0);
    drain("release_45");
    check("held_after_release", key_code, 4'h0);

    // Keypad plus, minus, unmapped code
    send_frame(8'h79, 1'b0, 1, 4'hA);
    send_frame(8'h7B, 1'b0, 1, 4'hB);
    send_frame(8'h1C, 1'b0, 1, 4'hC);
    drain("plus_minus_other");

    // Parity error then good frame
    send_frame(8'h26, 1'b1, 2, 4'h0);
    drain("parity_err");
    check("held_after_parity_err", key_code, 4'hC);
    send_frame(8'h26, 1'b0, 1, 4'h3);
    drain("press_26");

    // Truncated frame: start plus 4 data bits, then the bus goes quiet
    pb = 8'h3D;
    send_bit(1'b0, 1'b0, 0, 4'h0);
    for (int i = 0; i < 4; i++) send_bit(pb[i], 1'b0, 0, 4'h0);
    e.is_err = 1'b1;
    e.code   = 4'h0;
    e.cyc_lo = last_fall + 98;
    e.cyc_hi = last_fall + 106;
    exp_q.push_back(e);
    ps2_data = 1'b1;
    repeat (150) @(negedge clk);
    drain("timeout");
    check("held_after_timeout", key_code, 4'h3);
    send_frame(8'h3D, 1'b0, 1, 4'h7);
    drain("press_3D");

    // Reset in the middle of the data bits of 8'h46
    pb = 8'h46;
    send_bit(1'b0, 1'b0, 0, 4'h0);
    for (int i = 0; i < 3; i++) send_bit(pb[i], 1'b0, 0, 4'h0);
    ps2_data = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_key_code", key_code, 4'h0);
    check("midrst_key_valid", key_valid, 0);
    check("midrst_frame_err", frame_err, 0);
    repeat (200) @(negedge clk);
    send_frame(8'h46, 1'b0, 1, 4'h9);
    drain("press_46");
    repeat (20) @(negedge clk);
    check("final_key_code", key_code, 4'h9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, %0d expectations outstanding", exp_q.size());
    $fatal(1, "watchdog expired");
  end

endmodule
